nibble_result_collector: RTL and testbench

- Downstream stage of the nibble-serial FSM datapath (fsm_design).
- Consumes the N_width-bit result stream that the FSM drives during its OUTPUT state, qualified by output_valid.
- Reassembles the nibbles, least significant first, into one N-bit word and presents it on a valid/ready handshake for downstream logic.
- Flags overrun when a new stream starts before the held word is taken.

---
 rtl/nibble_result_collector.sv | 146 ++++++++++++++
 tb/tb_nibble_result_collector.sv | 314 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/nibble_result_collector.sv
// nibble_result_collector
//
// Downstream stage of the nibble-serial FSM datapath. Consumes the result
// stream the FSM drives while in its OUTPUT state (qualified by in_valid),
// reassembles the nibbles least-significant first into one N-bit word, and
// presents that word on a valid/ready handshake. A nibble that arrives while
// a finished word is still waiting to be taken is dropped and raises a sticky
// overrun flag.
//
// Ports:
//   clk        clock, all state updates on posedge
//   rst        asynchronous active-low reset
//   in_valid   nibble qualifier (FSM output_valid)
//   in_nibble  stream data (FSM out), N_width bits
//   clear      synchronous abort/flush, same effect as reset
//   word_ready downstream accepts the held word
//   word_valid assembled word available (decoded from state)
//   word       assembled N-bit word
//   nib_count  nibbles captured in the current word
//   busy       high whenever the collector is not idle
//   overrun    sticky error: nibble arrived while a word was held
//   xsum       (only with NIBBLE_COLLECT_XSUM_EN) XOR of accepted nibbles
//
// Optional feature macro: NIBBLE_COLLECT_XSUM_EN adds the xsum output and
// its accumulator. Without it the port and logic are absent.

module nibble_result_collector #(
  parameter int N       = 64,
  parameter int N_width = 4,
  localparam int NUM_NIB = N / N_width,
  localparam int CW      = $clog2(NUM_NIB)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  input  logic [N_width-1:0] in_nibble,
  input  logic               clear,
  input  logic               word_ready,
  output logic               word_valid,
  output logic [N-1:0]       word,
  output logic [CW-1:0]      nib_count,
  output logic               busy,
  output logic               overrun
`ifdef NIBBLE_COLLECT_XSUM_EN
  ,
  output logic [N_width-1:0] xsum
`endif
);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] COLLECT = 2'd1;
  localparam logic [1:0] HOLD    = 2'd2;

  logic [1:0] state;

  // Handshake outputs depend on state only, so downstream never sees a
  // combinational path from the stream inputs.
  assign word_valid = (state == HOLD);
  assign busy       = (state != IDLE);

  // Main collector. clear behaves exactly like reset but synchronously.
  // A word handed off in HOLD while a new nibble arrives restarts collection
  // at index 0 in the same edge, so back-to-back bursts lose nothing.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      word      <= '0;
      nib_count <= '0;
      overrun   <= 1'b0;
    end else if (clear) begin
      state     <= IDLE;
      word      <= '0;
      nib_count <= '0;
      overrun   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            word[N_width-1:0] <= in_nibble;
            nib_count         <= CW'(1);
            state             <= COLLECT;
          end
        end
        COLLECT: begin
          if (in_valid) begin
            for (int i = 0; i < NUM_NIB; i++) begin
              if (nib_count == CW'(i)) begin
                word[i*N_width +: N_width] <= in_nibble;
              end
            end
            if (nib_count == CW'(NUM_NIB - 1)) begin
              nib_count <= '0;
              state     <= HOLD;
            end else begin
              nib_count <= nib_count + CW'(1);
            end
          end
        end
        HOLD: begin
          if (word_ready) begin
            if (in_valid) begin
              word[N_width-1:0] <= in_nibble;
              nib_count         <= CW'(1);
              state             <= COLLECT;
            end else begin
              state <= IDLE;
            end
          end else if (in_valid) begin
            overrun <= 1'b1;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

`ifdef NIBBLE_COLLECT_XSUM_EN
  // Running XOR of the nibbles in the current word. Loaded on the index-0
  // write, accumulated on later writes, and left untouched while holding.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      xsum <= '0;
    end else if (clear) begin
      xsum <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) xsum <= in_nibble;
        end
        COLLECT: begin
          if (in_valid) xsum <= xsum ^ in_nibble;
        end
        HOLD: begin
          if (word_ready && in_valid) xsum <= in_nibble;
        end
        default: begin
          xsum <= '0;
        end
      endcase
    end
  end
`endif

endmodule

// File: tb/tb_nibble_result_collector.sv
// tb_nibble_result_collector
//
// Directed self-checking bench for nibble_result_collector (N=64, N_width=4).
// Each scenario task drives its own stimulus and compares outputs against
// hand-computed values; a single summary line reports the totals.

module tb_nibble_result_collector;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic [3:0]  in_nibble;
  logic        clear;
  logic        word_ready;
  logic        word_valid;
  logic [63:0] word;
  logic [3:0]  nib_count;
  logic        busy;
  logic        overrun;
`ifdef NIBBLE_COLLECT_XSUM_EN
  logic [3:0]  xsum;
`endif

  int checks = 0;
  int errors = 0;

  nibble_result_collector #(.N(64), .N_width(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_nibble  (in_nibble),
    .clear      (clear),
    .word_ready (word_ready),
    .word_valid (word_valid),
    .word       (word),
    .nib_count  (nib_count),
    .busy       (busy),
    .overrun    (overrun)
`ifdef NIBBLE_COLLECT_XSUM_EN
    ,
    .xsum       (xsum)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one clock and settle 1 ns past the edge before anything is read.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    in_valid   = 1'b0;
    in_nibble  = 4'h0;
    clear      = 1'b0;
    word_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    idle_inputs();
    #12;
    checks++;
    if (word_valid !== 1'b0 || busy !== 1'b0 || overrun !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_flags: got valid=%b busy=%b ovr=%b expected 0 0 0",
               word_valid, busy, overrun);
    end
    checks++;
    if (word !== 64'h0 || nib_count !== 4'h0) begin
      errors++;
      $display("[TB] FAIL reset_data: got word=%h cnt=%0d expected 0 0", word, nib_count);
    end
    @(negedge clk);
    rst = 1'b1;
    step();
  endtask

  // 16 contiguous nibbles 0..F with word_ready low.
  task automatic test_contiguous();
    for (int i = 0; i < 16; i++) begin
      in_valid  = 1'b1;
      in_nibble = 4'(i);
      step();
      if (i < 15) begin
        checks++;
        if (word_valid !== 1'b0 || nib_count !== 4'(i + 1)) begin
          errors++;
          $display("[TB] FAIL contig_progress[%0d]: got valid=%b cnt=%0d expected 0 %0d",
                   i, word_valid, nib_count, i + 1);
        end
      end
    end
    in_valid = 1'b0;
    checks++;
    if (word_valid !== 1'b1 || busy !== 1'b1 || nib_count !== 4'h0) begin
      errors++;
      $display("[TB] FAIL contig_hold: got valid=%b busy=%b cnt=%0d expected 1 1 0",
               word_valid, busy, nib_count);
    end
    checks++;
    if (word !== 64'hFEDCBA9876543210) begin
      errors++;
      $display("[TB] FAIL contig_word: got %h expected fedcba9876543210", word);
    end
`ifdef NIBBLE_COLLECT_XSUM_EN
    checks++;
    if (xsum !== 4'h0) begin
      errors++;
      $display("[TB] FAIL contig_xsum: got %h expected 0", xsum);
    end
`endif
    // Word stays held while word_ready is low.
    step();
    checks++;
    if (word_valid !== 1'b1 || word !== 64'hFEDCBA9876543210) begin
      errors++;
      $display("[TB] FAIL contig_stable: got valid=%b word=%h", word_valid, word);
    end
    word_ready = 1'b1;
    step();
    word_ready = 1'b0;
    checks++;
    if (word_valid !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("[TB] FAIL contig_release: got valid=%b busy=%b expected 0 0", word_valid, busy);
    end
  endtask

  // Same stream with gaps of 1..5 idle cycles between nibbles.
  task automatic test_gaps();
    for (int i = 0; i < 16; i++) begin
      in_valid  = 1'b1;
      in_nibble = 4'(i);
      step();
      in_valid  = 1'b0;
      in_nibble = 4'hC;
      if (i < 15) begin
        for (int g = 0; g < (i % 5) + 1; g++) begin
          step();
          checks++;
          if (word_valid !== 1'b0 || nib_count !== 4'(i + 1)) begin
            errors++;
            $display("[TB] FAIL gap_hold[%0d.%0d]: got valid=%b cnt=%0d expected 0 %0d",
                     i, g, word_valid, nib_count, i + 1);
          end
        end
      end
    end
    checks++;
    if (word_valid !== 1'b1 || word !== 64'hFEDCBA9876543210 || nib_count !== 4'h0) begin
      errors++;
      $display("[TB] FAIL gap_word: got valid=%b word=%h cnt=%0d expected 1 fedcba9876543210 0",
               word_valid, word, nib_count);
    end
    word_ready = 1'b1;
    step();
    word_ready = 1'b0;
  endtask

  // Two contiguous bursts with word_ready tied high.
  task automatic test_back_to_back();
    word_ready = 1'b1;
    for (int i = 0; i < 32; i++) begin
      in_valid  = 1'b1;
      in_nibble = (i < 16) ? 4'hA : 4'h5;
      step();
      if (i == 15) begin
        checks++;
        if (word_valid !== 1'b1 || word !== 64'hAAAAAAAAAAAAAAAA) begin
          errors++;
          $display("[TB] FAIL b2b_first: got valid=%b word=%h expected 1 aaaaaaaaaaaaaaaa",
                   word_valid, word);
        end
      end else if (i == 16) begin
        checks++;
        if (word_valid !== 1'b0 || nib_count !== 4'h1) begin
          errors++;
          $display("[TB] FAIL b2b_handoff: got valid=%b cnt=%0d expected 0 1", word_valid, nib_count);
        end
      end
    end
    in_valid = 1'b0;
    checks++;
    if (word_valid !== 1'b1 || word !== 64'h5555555555555555 || overrun !== 1'b0) begin
      errors++;
      $display("[TB] FAIL b2b_second: got valid=%b word=%h ovr=%b expected 1 5555555555555555 0",
               word_valid, word, overrun);
    end
    step();
    checks++;
    if (word_valid !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("[TB] FAIL b2b_idle: got valid=%b busy=%b expected 0 0", word_valid, busy);
    end
    word_ready = 1'b0;
  endtask

  // Extra nibble while a word is held sets sticky overrun.
  task automatic test_overrun();
    for (int i = 0; i < 16; i++) begin
      in_valid  = 1'b1;
      in_nibble = 4'(i);
      step();
    end
    in_nibble = 4'h3;
    step();
    in_valid = 1'b0;
    checks++;
    if (overrun !== 1'b1 || word_valid !== 1'b1 || word !== 64'hFEDCBA9876543210) begin
      errors++;
      $display("[TB] FAIL ovr_set: got ovr=%b valid=%b word=%h expected 1 1 fedcba9876543210",
               overrun, word_valid, word);
    end
    word_ready = 1'b1;
    step();
    word_ready = 1'b0;
    checks++;
    if (busy !== 1'b0 || overrun !== 1'b1) begin
      errors++;
      $display("[TB] FAIL ovr_sticky: got busy=%b ovr=%b expected 0 1", busy, overrun);
    end
    clear = 1'b1;
    step();
    clear = 1'b0;
    checks++;
    if (overrun !== 1'b0) begin
      errors++;
      $display("[TB] FAIL ovr_clear: got %b expected 0", overrun);
    end
  endtask

  // Asynchronous reset mid-COLLECT, then a fresh burst.
  task automatic test_async_reset();
    for (int i = 0; i < 7; i++) begin
      in_valid  = 1'b1;
      in_nibble = 4'h9;
      step();
    end
    in_valid = 1'b0;
    checks++;
    if (nib_count !== 4'h7 || busy !== 1'b1) begin
      errors++;
      $display("[TB] FAIL arst_pre: got cnt=%0d busy=%b expected 7 1", nib_count, busy);
    end
    #2 rst = 1'b0;
    #1;
    checks++;
    if (word !== 64'h0 || nib_count !== 4'h0 || busy !== 1'b0 || word_valid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL arst_now: got word=%h cnt=%0d busy=%b valid=%b expected 0 0 0 0",
               word, nib_count, busy, word_valid);
    end
    #2 rst = 1'b1;
    step();
    for (int i = 0; i < 16; i++) begin
      in_valid  = 1'b1;
      in_nibble = 4'(15 - i);
      step();
    end
    in_valid = 1'b0;
    checks++;
    if (word_valid !== 1'b1 || word !== 64'h0123456789ABCDEF) begin
      errors++;
      $display("[TB] FAIL arst_reburst: got valid=%b word=%h expected 1 0123456789abcdef",
               word_valid, word);
    end
  endtask

  // clear beats a simultaneous handoff in HOLD (entered from previous task).
  task automatic test_clear_priority();
    in_valid  = 1'b1;
    in_nibble = 4'h6;
    step();
    checks++;
    if (overrun !== 1'b1) begin
      errors++;
      $display("[TB] FAIL clr_setup: got ovr=%b expected 1", overrun);
    end
    clear      = 1'b1;
    word_ready = 1'b1;
    in_nibble  = 4'h7;
    step();
    idle_inputs();
    checks++;
    if (busy !== 1'b0 || word !== 64'h0 || nib_count !== 4'h0 ||
        word_valid !== 1'b0 || overrun !== 1'b0) begin
      errors++;
      $display("[TB] FAIL clr_wins: got busy=%b word=%h cnt=%0d valid=%b ovr=%b expected 0 0 0 0 0",
               busy, word, nib_count, word_valid, overrun);
    end
    step();
    checks++;
    if (busy !== 1'b0 || nib_count !== 4'h0) begin
      errors++;
      $display("[TB] FAIL clr_dropped: got busy=%b cnt=%0d expected 0 0", busy, nib_count);
    end
  endtask

  initial begin
    test_reset();
    test_contiguous();
    test_gaps();
    test_back_to_back();
    test_overrun();
    test_async_reset();
    test_clear_priority();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
